// File: rtl/serial_invert_packer.sv
// Serial-to-parallel packer: stores the complement of each accepted bit, LSB first,
// into a WIDTH-bit word. Define SERIAL_INVERT_PACKER_PARITY_EN to add a parallel_parity output.
module serial_invert_packer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  output logic             serial_ready,
  output logic             parallel_valid,
  output logic [WIDTH-1:0] parallel_data,
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
  output logic             parallel_parity,
`endif
  input  logic             parallel_ready
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] word_next;
  logic             inv_bit;
  logic             accept;
  logic             last_bit;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Inverter built as a 2:1 mux selecting constant 0 or 1.
  assign inv_bit = serial_data ? 1'b0 : 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch can be inferred.
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
    parity_d  = parity_q;
`endif

    // Only the final bit of a word can stall, and only when the output is still occupied.
    serial_ready = !((cnt_q == CNT_LAST) && valid_q && !parallel_ready);
    accept       = serial_valid && serial_ready;
    last_bit     = accept && (cnt_q == CNT_LAST);

    word_next          = shift_q;
    word_next[cnt_q]   = inv_bit;

    if (valid_q && parallel_ready) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      shift_d = word_next;
      cnt_d   = cnt_q + 1'b1;
    end

    // A completing word overrides the drain, so back-to-back words leave no bubble.
    if (last_bit) begin
      cnt_d    = '0;
      shift_d  = '0;
      data_d   = word_next;
      valid_d  = 1'b1;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
      parity_d = ^word_next;
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the partial word is reset too, so a reset mid-word leaves no stale bits behind.
      cnt_q    <= '0;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign parallel_valid  = valid_q;
  assign parallel_data   = data_q;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
  assign parallel_parity = parity_q;
`endif

endmodule

// File: tb/tb_serial_invert_packer.sv
// Scoreboard bench for serial_invert_packer: a predictor pushes expected words from a
// queue-based reference model, and a separate monitor pops and compares delivered words.
module tb_serial_invert_packer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_valid = 1'b0;
  logic         serial_data = 1'b0;
  logic         serial_ready;
  logic         parallel_valid;
  logic [W-1:0] parallel_data;
  logic         parallel_ready = 1'b0;
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
  logic         parallel_parity;
`endif

  serial_invert_packer #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_valid   (serial_valid),
    .serial_data    (serial_data),
    .serial_ready   (serial_ready),
    .parallel_valid (parallel_valid),
    .parallel_data  (parallel_data),
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
    .parallel_parity(parallel_parity),
`endif
    .parallel_ready (parallel_ready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: raw accepted bits of the current word, expected words, output occupancy.
  logic         bits_q[$];
  logic [W-1:0] exp_q[$];
  logic         out_full = 1'b0;
  logic         hold = 1'b0;
  logic [W-1:0] hold_data;

  // Predictor: samples inputs mid-cycle and advances the model across the coming edge.
  always @(negedge clk) begin
    logic         exp_rdy;
    logic         drain;
    logic         complete;
    logic [W-1:0] word;
    if (!rst) begin
      exp_rdy = !((bits_q.size() == W - 1) && out_full && !parallel_ready);
      check("serial_ready", {31'd0, serial_ready}, {31'd0, exp_rdy});
      check("parallel_valid", {31'd0, parallel_valid}, {31'd0, out_full});
      drain    = out_full && parallel_ready;
      complete = 1'b0;
      if (serial_valid && exp_rdy) begin
        bits_q.push_back(serial_data);
        if (bits_q.size() == W) begin
          word = '0;
          for (int i = 0; i < W; i++) word[i] = ~bits_q[i];
          exp_q.push_back(word);
          bits_q.delete();
          complete = 1'b1;
        end
      end
      out_full = complete ? 1'b1 : (drain ? 1'b0 : out_full);
    end
  end

  // Monitor: compares every presented word against the oldest expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        check("hold_valid", {31'd0, parallel_valid}, 32'd1);
        check("hold_data", {24'd0, parallel_data}, {24'd0, hold_data});
      end
      hold = 1'b0;
      if (parallel_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", parallel_data, $time);
        end else begin
          check("word", {24'd0, parallel_data}, {24'd0, exp_q[0]});
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
          check("parity", {31'd0, parallel_parity}, {31'd0, ^exp_q[0]});
`endif
          if (parallel_ready) begin
            void'(exp_q.pop_front());
            n_xfer++;
          end else begin
            hold      = 1'b1;
            hold_data = parallel_data;
          end
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic d, input logic pr);
    serial_valid   = v;
    serial_data    = d;
    parallel_ready = pr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous pulse placed between clock edges; outputs must clear without a clock.
  task automatic pulse_reset(input string name);
    #1 rst = 1'b1;
    #1;
    check({name, "_valid"}, {31'd0, parallel_valid}, 32'd0);
    check({name, "_data"}, {24'd0, parallel_data}, 32'd0);
    check({name, "_sready"}, {31'd0, serial_ready}, 32'd1);
    bits_q.delete();
    exp_q.delete();
    out_full = 1'b0;
    hold     = 1'b0;
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    int         x0;

    #2;
    check("rst_valid", {31'd0, parallel_valid}, 32'd0);
    check("rst_data", {24'd0, parallel_data}, 32'd0);
    check("rst_sready", {31'd0, serial_ready}, 32'd1);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic word: 1,0,1,1,0,0,1,0 packs to 0xB2.
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) cyc(1'b1, pat[i], 1'b1);
    check("basic_valid", {31'd0, parallel_valid}, 32'd1);
    check("basic_data", {24'd0, parallel_data}, 32'hB2);
`ifdef SERIAL_INVERT_PACKER_PARITY_EN
    check("basic_parity", {31'd0, parallel_parity}, 32'd0);
`endif
    idle(2);

    // Constant streams.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b1);
    check("zeros_data", {24'd0, parallel_data}, 32'hFF);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1);
    check("ones_data", {24'd0, parallel_data}, 32'h00);
    idle(2);

    // Backpressure: 16th bit stalls until the first word drains.
    x0 = n_xfer;
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      serial_valid = 1'b1; serial_data = 1'b0; parallel_ready = 1'b0;
      #1;
      check("bp_sready_low", {31'd0, serial_ready}, 32'd0);
      check("bp_first_word", {24'd0, parallel_data}, 32'hFF);
      @(posedge clk);
      #1;
    end
    cyc(1'b1, 1'b0, 1'b1);
    check("bp_second_valid", {31'd0, parallel_valid}, 32'd1);
    idle(2);
    check("bp_transfers", n_xfer - x0, 32'd2);

    // Simultaneous drain and load on the 16th bit.
    x0 = n_xfer;
    for (int i = 0; i < 15; i++) cyc(1'b1, i[0], 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("sim_valid_kept", {31'd0, parallel_valid}, 32'd1);
    check("sim_data", {24'd0, parallel_data}, 32'h55);
    idle(2);
    check("sim_transfers", n_xfer - x0, 32'd2);

    // Reset mid-word: the 5 partial bits vanish.
    x0 = n_xfer;
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1);
    pulse_reset("rst_mid");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b1);
    check("rst_mid_data", {24'd0, parallel_data}, 32'h00);
    idle(2);
    check("rst_mid_transfers", n_xfer - x0, 32'd1);

    // Reset with a word pending: the word is dropped.
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    pulse_reset("rst_pend");
    idle(2);
    check("rst_pend_transfers", n_xfer - x0, 32'd0);

    // Gapped input: data toggles freely while serial_valid is low.
    for (int i = 0; i < 32; i++) cyc(i[0] == 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    idle(2);

    // Random traffic with random backpressure.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 1) == 1);
    idle(4);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
